// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM state
// codes and the datapath select/ALU control encodings.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_JR       = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'b000,
    ALU_FUNCT   = 3'b001,
    ALU_AND     = 3'b010,
    ALU_OR      = 3'b011,
    ALU_SUB_BEQ = 3'b100,
    ALU_SUB_BNE = 3'b101,
    ALU_SLT     = 3'b110,
    ALU_PASS    = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RS     = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_RA = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'b00,
    WB_MDR    = 2'b01,
    WB_PC     = 2'b10
  } mem_to_reg_e;

  // ALU operation for the immediate-form arithmetic/logic instructions.
  function automatic alu_op_e imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // States that own the shared memory port and may stall on mem_ready.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory-wait watchdog: counts stalled cycles in a memory state and fires
// when the stall reaches MEM_TIMEOUT cycles; keeps a sticky timeout flag.
module mem_watchdog #(
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic wait_en,
  output logic fire,
  output logic timed_out
);

  logic [TMO_W-1:0] count;

  assign fire = wait_en && (count == TMO_W'(MEM_TIMEOUT - 1));

  // Stall counter and sticky flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      timed_out <= 1'b0;
    end else begin
      if (clr)          count <= '0;
      else if (wait_en) count <= count + 1'b1;
      if (fire) timed_out <= 1'b1;
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a shared
// req/ready memory port, traps on illegal opcodes and memory timeouts.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic [3:0]         state_o,
  output logic               illegal_op,
  output logic               mem_timeout
);

  state_e     state, next_state;
  logic [5:0] op_q;
  logic       wd_fire;
  alu_op_e    aop;

  mem_watchdog #(
    .TMO_W      (TMO_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (next_state != state),
    .wait_en  (is_mem_state(state) && !mem_ready),
    .fire     (wd_fire),
    .timed_out(mem_timeout)
  );

  // Next-state selection, including stall, timeout and decode dispatch.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
                  else if (wd_fire) next_state = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                       next_state = (funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:                   next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                 next_state = S_BRANCH;
          OP_J:                           next_state = S_JUMP;
          OP_JAL:                         next_state = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_EXEC_I;
          default:                        next_state = S_TRAP;
        endcase
      end
      S_MEM_ADDR: next_state = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) next_state = S_MEM_WB;
                  else if (wd_fire) next_state = S_TRAP;
      S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
                  else if (wd_fire) next_state = S_TRAP;
      S_EXEC_R, S_EXEC_I: next_state = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JR, S_JAL: next_state = S_FETCH;
      default:    next_state = S_TRAP;
    endcase
  end

  // State register, opcode capture at DECODE and sticky illegal-opcode flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      op_q       <= '0;
      illegal_op <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q <= opcode;
        if (next_state == S_TRAP) illegal_op <= 1'b1;
      end
    end
  end

  // Output decode from the current state, with Mealy terms for fetch
  // completion and the branch condition.
  // NOTE: rst gates the decode directly so outputs (mem_req in particular)
  // drop asynchronously instead of waiting for a clock edge.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    aop        = ALU_ADD;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALUOUT;
    reg_write  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = SRCB_IMM_SH2;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = WB_MDR;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          aop       = ALU_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          aop       = imm_alu_op(op_q);
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = (op_q == OP_RTYPE) ? DST_RD : DST_RT;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          pc_src    = PC_ALUOUT;
          aop       = (op_q == OP_BNE) ? ALU_SUB_BNE : ALU_SUB_BEQ;
          pc_write  = (op_q == OP_BNE) ? !zero : zero;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = PC_RS;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          reg_write  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = WB_PC;
        end
        default: ;
      endcase
    end
  end

  assign alu_op  = ALUOP_W'(aop);
  assign state_o = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: table-driven instruction
// latencies, hand-written corner sequences and a randomized run, all checked
// cycle by cycle against an instruction-level reference model.
module tb_mips_multicycle_control;

  localparam int TMO = 5;

  // Phase codes as the debug state output reports them.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEM_ADDR = 2, P_MEM_RD = 3,
                 P_MEM_WB = 4, P_MEM_WR = 5, P_EXEC_R = 6, P_ALU_WB = 7,
                 P_BRANCH = 8, P_JUMP = 9, P_EXEC_I = 10, P_JR = 11,
                 P_JAL = 12, P_TRAP = 13;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [3:0] state;
    logic       illegal;
    logic       tmo;
  } out_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    int         pcw;
    int         rw;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, reg_write;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  logic       illegal_op, mem_timeout;
  out_t       dut_o;

  int n_checks = 0;
  int n_fail   = 0;

  mips_multicycle_control #(
    .ALUOP_W    (3),
    .TMO_W      (8),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .state_o    (state_o),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout)
  );

  assign dut_o = '{mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, state_o,
                   illegal_op, mem_timeout};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  // ---------------- reference model (instruction-level) ----------------
  int         m_phase;
  int         m_plan[$];
  logic [5:0] m_op;
  int         m_wait;
  logic       m_ill, m_tmo;

  task automatic model_reset();
    m_phase = P_FETCH;
    m_plan.delete();
    m_op   = '0;
    m_wait = 0;
    m_ill  = 1'b0;
    m_tmo  = 1'b0;
  endtask

  function automatic out_t model_out(input logic rdy, input logic z);
    out_t o = '0;
    case (m_phase)
      P_FETCH:    begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      P_DECODE:   o.alu_src_b = 2'b11;
      P_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_MEM_RD:   begin o.mem_req = 1; o.iord = 1; end
      P_MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 2'b01; end
      P_MEM_WR:   begin o.mem_req = 1; o.iord = 1; o.mem_we = 1; end
      P_EXEC_R:   begin o.alu_src_a = 1; o.alu_op = 3'b001; end
      P_ALU_WB:   begin o.reg_write = 1; o.reg_dst = (m_op == 6'b000000) ? 2'b01 : 2'b00; end
      P_BRANCH: begin
        o.alu_src_a = 1;
        o.pc_src    = 2'b01;
        if (m_op == 6'b000100) begin o.alu_op = 3'b100; o.pc_write = z; end
        else                   begin o.alu_op = 3'b101; o.pc_write = !z; end
      end
      P_JUMP:     begin o.pc_write = 1; o.pc_src = 2'b10; end
      P_EXEC_I: begin
        o.alu_src_a = 1;
        o.alu_src_b = 2'b10;
        o.alu_op = (m_op == 6'b001100) ? 3'b010 :
                   (m_op == 6'b001101) ? 3'b011 :
                   (m_op == 6'b001010) ? 3'b110 : 3'b000;
      end
      P_JR:       begin o.pc_write = 1; o.pc_src = 2'b11; end
      P_JAL: begin
        o.pc_write = 1; o.pc_src = 2'b10; o.reg_write = 1;
        o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
      end
      default: ;
    endcase
    o.state   = 4'(m_phase);
    o.illegal = m_ill;
    o.tmo     = m_tmo;
    return o;
  endfunction

  // Move to the next phase of the current instruction's plan.
  task automatic model_advance();
    if (m_phase == P_FETCH) begin
      m_phase = P_DECODE;
    end else if (m_phase == P_DECODE) begin
      m_op = opcode;
      case (opcode)
        6'b000000: if (funct == 6'b001000) m_plan = '{P_JR};
                   else m_plan = '{P_EXEC_R, P_ALU_WB};
        6'b100011: m_plan = '{P_MEM_ADDR, P_MEM_RD, P_MEM_WB};
        6'b101011: m_plan = '{P_MEM_ADDR, P_MEM_WR};
        6'b000100, 6'b000101: m_plan = '{P_BRANCH};
        6'b000010: m_plan = '{P_JUMP};
        6'b000011: m_plan = '{P_JAL};
        6'b001000, 6'b001100, 6'b001101, 6'b001010: m_plan = '{P_EXEC_I, P_ALU_WB};
        default:   m_plan = '{P_TRAP};
      endcase
      m_phase = m_plan.pop_front();
      if (m_phase == P_TRAP) m_ill = 1'b1;
    end else if (m_plan.size() > 0) begin
      m_phase = m_plan.pop_front();
    end else begin
      m_phase = P_FETCH;
    end
  endtask

  task automatic model_step(input logic rdy);
    if (m_phase == P_TRAP) begin
      // absorbing
    end else if (m_phase == P_FETCH || m_phase == P_MEM_RD || m_phase == P_MEM_WR) begin
      if (rdy) begin
        m_wait = 0;
        model_advance();
      end else if (m_wait == TMO - 1) begin
        m_wait  = 0;
        m_phase = P_TRAP;
        m_tmo   = 1'b1;
      end else begin
        m_wait++;
      end
    end else begin
      model_advance();
    end
  endtask

  // ---------------- bench helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at edge+1, compare at edge+4, advance model.
  task automatic step(input logic rdy, input logic z, output out_t got);
    out_t exp;
    mem_ready = rdy;
    zero      = z;
    #3;
    exp = model_out(rdy, z);
    got = dut_o;
    check("cycle_outputs", {8'h0, got}, {8'h0, exp});
    model_step(rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    check("reset_outputs", {8'h0, dut_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Run one instruction from FETCH back to FETCH (or into TRAP).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw_n, input int mw_n,
                           output int cycles, output int pcw, output int rw, output int m2r);
    out_t got;
    int   prev;
    int   fw = 0;
    int   mw = 0;
    logic rdy;
    opcode = op;
    funct  = fn;
    cycles = 0; pcw = 0; rw = 0; m2r = 0;
    do begin
      prev = m_phase;
      if (m_phase == P_FETCH) begin
        rdy = (fw >= fw_n); fw++;
      end else if (m_phase == P_MEM_RD || m_phase == P_MEM_WR) begin
        rdy = (mw >= mw_n); mw++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      step(rdy, z, got);
      cycles++;
      if (got.pc_write) pcw++;
      if (got.reg_write) rw++;
      if (got.reg_write && got.mem_to_reg == 2'b01) m2r++;
    end while (!((m_phase == P_FETCH && prev != P_FETCH) || m_phase == P_TRAP) && cycles < 40);
    if (cycles >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL instr_cycle_budget: op 0x%0h still running after %0d cycles", op, cycles);
    end
  endtask

  logic [5:0] legal_ops [12] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                                  6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0A};

  vec_t vecs[15];

  initial begin
    out_t got;
    int   cyc, pcw, rw, m2r, trap_cnt;

    rst = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    model_reset();
    #1;

    vecs[0]  = '{"add",      6'h00, 6'h20, 1'b0, 4, 1, 1};
    vecs[1]  = '{"jr",       6'h00, 6'h08, 1'b0, 3, 2, 0};
    vecs[2]  = '{"lw",       6'h23, 6'h00, 1'b0, 5, 1, 1};
    vecs[3]  = '{"sw",       6'h2B, 6'h00, 1'b0, 4, 1, 0};
    vecs[4]  = '{"beq_z1",   6'h04, 6'h00, 1'b1, 3, 2, 0};
    vecs[5]  = '{"beq_z0",   6'h04, 6'h00, 1'b0, 3, 1, 0};
    vecs[6]  = '{"bne_z1",   6'h05, 6'h00, 1'b1, 3, 1, 0};
    vecs[7]  = '{"bne_z0",   6'h05, 6'h00, 1'b0, 3, 2, 0};
    vecs[8]  = '{"j",        6'h02, 6'h00, 1'b0, 3, 2, 0};
    vecs[9]  = '{"jal",      6'h03, 6'h00, 1'b0, 3, 2, 1};
    vecs[10] = '{"addi",     6'h08, 6'h00, 1'b0, 4, 1, 1};
    vecs[11] = '{"andi",     6'h0C, 6'h00, 1'b0, 4, 1, 1};
    vecs[12] = '{"ori",      6'h0D, 6'h00, 1'b0, 4, 1, 1};
    vecs[13] = '{"slti",     6'h0A, 6'h00, 1'b1, 4, 1, 1};
    vecs[14] = '{"sub",      6'h00, 6'h22, 1'b1, 4, 1, 1};

    do_reset();

    // Table: zero-wait latency and strobe counts per instruction.
    for (int i = 0; i < 15; i++) begin
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, 0, 0, cyc, pcw, rw, m2r);
      check({vecs[i].name, "_latency"}, 32'(cyc), 32'(vecs[i].lat));
      check({vecs[i].name, "_pc_write_count"}, 32'(pcw), 32'(vecs[i].pcw));
      check({vecs[i].name, "_reg_write_count"}, 32'(rw), 32'(vecs[i].rw));
    end

    // lw with three wait states in MEM_RD.
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, cyc, pcw, rw, m2r);
    check("lw_wait3_latency", 32'(cyc), 32'd8);
    check("lw_wait3_reg_write_count", 32'(rw), 32'd1);
    check("lw_wait3_mdr_writeback", 32'(m2r), 32'd1);

    // Fetch stalls shorter than the timeout complete normally.
    run_instr(6'h2B, 6'h00, 1'b0, 3, 2, cyc, pcw, rw, m2r);
    check("sw_stalled_latency", 32'(cyc), 32'd9);

    // Illegal opcode traps and stays quiet until reset.
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, cyc, pcw, rw, m2r);
    check("illegal_cycles_to_trap", 32'(cyc), 32'd2);
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b1, got);
    check("illegal_state", 32'(got.state), 32'd13);
    check("illegal_flag", 32'(got.illegal), 32'd1);
    check("illegal_strobes", {28'h0, got.mem_req, got.ir_write, got.pc_write, got.reg_write}, 32'h0);
    do_reset();
    opcode = 6'h00; funct = 6'h20;
    step(1'b0, 1'b0, got);
    check("post_trap_state", 32'(got.state), 32'd0);
    check("post_trap_fetch_req", {30'h0, got.mem_req, got.iord}, 32'h2);
    check("post_trap_illegal_cleared", 32'(got.illegal), 32'd0);

    // Watchdog: ready held low in FETCH traps on the sixth cycle.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, got);
    check("tmo_state_cycle5", 32'(got.state), 32'd0);
    step(1'b0, 1'b0, got);
    check("tmo_state_cycle6", 32'(got.state), 32'd13);
    check("tmo_flag", 32'(got.tmo), 32'd1);
    check("tmo_no_illegal", 32'(got.illegal), 32'd0);

    // Watchdog: ready arriving on the limit cycle wins.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, got);
    step(1'b1, 1'b0, got);
    check("tmo_edge_ir_write", 32'(got.ir_write), 32'd1);
    step(1'b0, 1'b0, got);
    check("tmo_edge_decode", 32'(got.state), 32'd1);
    check("tmo_edge_no_flag", 32'(got.tmo), 32'd0);

    // Reset asserted mid-access drops mem_req without a clock edge.
    do_reset();
    opcode = 6'h23; funct = 6'h00;
    step(1'b1, 1'b0, got);
    step(1'b0, 1'b0, got);
    step(1'b0, 1'b0, got);
    mem_ready = 1'b0;
    #3;
    check("midrst_mem_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_mem_req_after", 32'(mem_req), 32'd0);
    check("midrst_state", 32'(state_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Randomized run against the model.
    trap_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_phase == P_FETCH) begin
        opcode = ($urandom_range(0, 15) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 11)];
        funct  = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
      end
      if (m_phase == P_TRAP) begin
        trap_cnt++;
        if (trap_cnt > 3) begin
          trap_cnt = 0;
          do_reset();
          continue;
        end
      end
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
